// File: rtl/ar_channel_router_if.sv
// AXI read-address channel bundle.
// master drives the request, slave returns ARREADY.
interface ar_channel_router_if #(
  parameter int ID_W   = 2,
  parameter int ADDR_W = 32,
  parameter int USER_W = 1
) ();
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic [USER_W-1:0] ARUSER;
  logic              ARVALID;
  logic              ARREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE,
    output ARBURST, ARLOCK, ARCACHE,
    output ARPROT, ARUSER, ARVALID,
    input  ARREADY
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE,
    input  ARBURST, ARLOCK, ARCACHE,
    input  ARPROT, ARUSER, ARVALID,
    output ARREADY
  );
endinterface

// File: rtl/ar_channel_router.sv
// AR router: decodes one master to five slaves,
// tags IDs with a sequence number, logs slave order.
module ar_channel_router #(
  parameter int ADDR_width = 32,
  parameter int mID_width  = 2,
  parameter int seq_width  = 4,
  parameter int sID_width  = 6,
  parameter int user_width = 1,
  parameter int SEL_msb    = 31,
  parameter int ORD_depth  = 8
) (
  input  logic clk,
  input  logic reset,
  ar_channel_router_if.slave  m_ar,
  ar_channel_router_if.master s0_ar,
  ar_channel_router_if.master s1_ar,
  ar_channel_router_if.master s2_ar,
  ar_channel_router_if.master s3_ar,
  ar_channel_router_if.master s4_ar,
  input  logic       r_done,
  output logic [2:0] ord_sel,
  output logic       ord_empty,
  output logic       ord_full
);
  localparam int PW = $clog2(ORD_depth) + 1;
  localparam int AW = PW - 1;

  typedef struct packed {
    logic [sID_width-1:0]  id;
    logic [ADDR_width-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [user_width-1:0] user;
  } hold_t;

  hold_t          hold_q, hold_d;
  logic [2:0]     hold_sel_q, hold_sel_d;
  logic           busy_q, busy_d;
  logic [seq_width-1:0] seq_q, seq_d;
  logic [PW-1:0]  wr_q, wr_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [2:0]     mem_q [ORD_depth];
  logic [2:0]     mem_d [ORD_depth];

  logic [2:0] raw_sel;
  logic [2:0] dec_sel;
  logic       sel_ready;
  logic       accept;
  logic       slv_hs;
  logic       pop;

  assign raw_sel = m_ar.ARADDR[SEL_msb -: 3];
  // Unmapped select codes fall to the default slave.
  assign dec_sel = (raw_sel > 3'd4) ? 3'd4 : raw_sel;

  always_comb begin
    sel_ready = 1'b0;
    unique case (hold_sel_q)
      3'd0:    sel_ready = s0_ar.ARREADY;
      3'd1:    sel_ready = s1_ar.ARREADY;
      3'd2:    sel_ready = s2_ar.ARREADY;
      3'd3:    sel_ready = s3_ar.ARREADY;
      default: sel_ready = s4_ar.ARREADY;
    endcase
  end

  assign ord_empty = (wr_q == rd_q);
  assign ord_full  = (wr_q[AW] != rd_q[AW])
                  && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign ord_sel   = ord_empty ? 3'd0
                   : mem_q[rd_q[AW-1:0]];

  assign m_ar.ARREADY = !reset && !ord_full
                     && (!busy_q || sel_ready);
  assign accept = m_ar.ARVALID && m_ar.ARREADY;
  assign slv_hs = busy_q && sel_ready;
  assign pop    = r_done && !ord_empty;

  always_comb begin
    hold_d     = hold_q;
    hold_sel_d = hold_sel_q;
    busy_d     = busy_q;
    seq_d      = seq_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    mem_d      = mem_q;
    if (accept) begin
      hold_d = {m_ar.ARID, seq_q,
                m_ar.ARADDR, m_ar.ARLEN,
                m_ar.ARSIZE, m_ar.ARBURST,
                m_ar.ARLOCK, m_ar.ARCACHE,
                m_ar.ARPROT, m_ar.ARUSER};
      hold_sel_d = dec_sel;
      busy_d     = 1'b1;
      seq_d      = seq_q + 1'b1;
      mem_d[wr_q[AW-1:0]] = dec_sel;
      wr_d       = wr_q + 1'b1;
    end else if (slv_hs) begin
      busy_d = 1'b0;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q     <= '0;
      hold_sel_q <= '0;
      busy_q     <= 1'b0;
      seq_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      mem_q      <= '{default: '0};
    end else begin
      hold_q     <= hold_d;
      hold_sel_q <= hold_sel_d;
      busy_q     <= busy_d;
      seq_q      <= seq_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
    end
  end

  assign s0_ar.ARVALID = busy_q && (hold_sel_q == 3'd0);
  assign s1_ar.ARVALID = busy_q && (hold_sel_q == 3'd1);
  assign s2_ar.ARVALID = busy_q && (hold_sel_q == 3'd2);
  assign s3_ar.ARVALID = busy_q && (hold_sel_q == 3'd3);
  assign s4_ar.ARVALID = busy_q && (hold_sel_q == 3'd4);

  assign {s0_ar.ARID, s0_ar.ARADDR, s0_ar.ARLEN,
          s0_ar.ARSIZE, s0_ar.ARBURST, s0_ar.ARLOCK,
          s0_ar.ARCACHE, s0_ar.ARPROT,
          s0_ar.ARUSER} = hold_q;
  assign {s1_ar.ARID, s1_ar.ARADDR, s1_ar.ARLEN,
          s1_ar.ARSIZE, s1_ar.ARBURST, s1_ar.ARLOCK,
          s1_ar.ARCACHE, s1_ar.ARPROT,
          s1_ar.ARUSER} = hold_q;
  assign {s2_ar.ARID, s2_ar.ARADDR, s2_ar.ARLEN,
          s2_ar.ARSIZE, s2_ar.ARBURST, s2_ar.ARLOCK,
          s2_ar.ARCACHE, s2_ar.ARPROT,
          s2_ar.ARUSER} = hold_q;
  assign {s3_ar.ARID, s3_ar.ARADDR, s3_ar.ARLEN,
          s3_ar.ARSIZE, s3_ar.ARBURST, s3_ar.ARLOCK,
          s3_ar.ARCACHE, s3_ar.ARPROT,
          s3_ar.ARUSER} = hold_q;
  assign {s4_ar.ARID, s4_ar.ARADDR, s4_ar.ARLEN,
          s4_ar.ARSIZE, s4_ar.ARBURST, s4_ar.ARLOCK,
          s4_ar.ARCACHE, s4_ar.ARPROT,
          s4_ar.ARUSER} = hold_q;
endmodule

// File: tb/tb_ar_channel_router.sv
// Bench for ar_channel_router: directed scenarios then
// random traffic against a queue-based reference model.
module tb_ar_channel_router;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic r_done = 1'b0;
  logic [2:0] ord_sel;
  logic ord_empty;
  logic ord_full;

  always #5 clk = ~clk;

  ar_channel_router_if #(.ID_W(2)) m_if ();
  ar_channel_router_if #(.ID_W(6)) s0_if ();
  ar_channel_router_if #(.ID_W(6)) s1_if ();
  ar_channel_router_if #(.ID_W(6)) s2_if ();
  ar_channel_router_if #(.ID_W(6)) s3_if ();
  ar_channel_router_if #(.ID_W(6)) s4_if ();

  ar_channel_router dut (
    .clk(clk), .reset(reset), .m_ar(m_if),
    .s0_ar(s0_if), .s1_ar(s1_if), .s2_ar(s2_if),
    .s3_ar(s3_if), .s4_ar(s4_if),
    .r_done(r_done), .ord_sel(ord_sel),
    .ord_empty(ord_empty), .ord_full(ord_full)
  );

  logic [4:0]  srdy = '0;
  logic [4:0]  svld;
  logic [59:0] spay [5];

  assign s0_if.ARREADY = srdy[0];
  assign s1_if.ARREADY = srdy[1];
  assign s2_if.ARREADY = srdy[2];
  assign s3_if.ARREADY = srdy[3];
  assign s4_if.ARREADY = srdy[4];
  assign svld = {s4_if.ARVALID, s3_if.ARVALID,
                 s2_if.ARVALID, s1_if.ARVALID,
                 s0_if.ARVALID};
  assign spay[0] = {s0_if.ARID, s0_if.ARADDR,
    s0_if.ARLEN, s0_if.ARSIZE, s0_if.ARBURST,
    s0_if.ARLOCK, s0_if.ARCACHE, s0_if.ARPROT,
    s0_if.ARUSER};
  assign spay[1] = {s1_if.ARID, s1_if.ARADDR,
    s1_if.ARLEN, s1_if.ARSIZE, s1_if.ARBURST,
    s1_if.ARLOCK, s1_if.ARCACHE, s1_if.ARPROT,
    s1_if.ARUSER};
  assign spay[2] = {s2_if.ARID, s2_if.ARADDR,
    s2_if.ARLEN, s2_if.ARSIZE, s2_if.ARBURST,
    s2_if.ARLOCK, s2_if.ARCACHE, s2_if.ARPROT,
    s2_if.ARUSER};
  assign spay[3] = {s3_if.ARID, s3_if.ARADDR,
    s3_if.ARLEN, s3_if.ARSIZE, s3_if.ARBURST,
    s3_if.ARLOCK, s3_if.ARCACHE, s3_if.ARPROT,
    s3_if.ARUSER};
  assign spay[4] = {s4_if.ARID, s4_if.ARADDR,
    s4_if.ARLEN, s4_if.ARSIZE, s4_if.ARBURST,
    s4_if.ARLOCK, s4_if.ARCACHE, s4_if.ARPROT,
    s4_if.ARUSER};

  int pass = 0;
  int total = 0;

  // Reference model: transaction-level view.
  int          q[$];
  bit          m_busy = 0;
  int          m_sel = 0;
  int          m_seq = 0;
  logic [59:0] m_hold = '0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  function automatic int dec(input logic [31:0] a);
    int s;
    s = int'(a[31:29]);
    return (s > 4) ? 4 : s;
  endfunction

  task automatic go(input bit v,
                    input logic [31:0] a,
                    input logic [1:0] id,
                    input logic [4:0] rdy,
                    input bit rd);
    bit er, hs, acc, popok;
    int tmp;
    m_if.ARVALID = v;
    m_if.ARADDR  = a;
    m_if.ARID    = id;
    m_if.ARLEN   = 8'($urandom);
    m_if.ARSIZE  = 3'($urandom);
    m_if.ARBURST = 2'($urandom);
    m_if.ARLOCK  = 1'($urandom);
    m_if.ARCACHE = 4'($urandom);
    m_if.ARPROT  = 3'($urandom);
    m_if.ARUSER  = 1'($urandom);
    srdy   = rdy;
    r_done = rd;
    #1;
    er = !reset && (q.size() != 8)
      && (!m_busy || rdy[m_sel]);
    chk("m_ARREADY", 64'(m_if.ARREADY), 64'(er));
    if (reset) begin
      m_busy = 0; m_seq = 0; m_hold = '0;
      m_sel = 0; q.delete();
    end else begin
      hs    = m_busy && rdy[m_sel];
      acc   = v && er;
      popok = rd && (q.size() > 0);
      if (popok) tmp = q.pop_front();
      if (acc) begin
        m_hold = {id, 4'(m_seq), a,
                  m_if.ARLEN, m_if.ARSIZE,
                  m_if.ARBURST, m_if.ARLOCK,
                  m_if.ARCACHE, m_if.ARPROT,
                  m_if.ARUSER};
        m_sel  = dec(a);
        m_seq  = (m_seq + 1) % 16;
        q.push_back(m_sel);
        m_busy = 1;
      end else if (hs) begin
        m_busy = 0;
      end
    end
    @(negedge clk);
    chk("s_ARVALID", 64'(svld),
        m_busy ? 64'(5'b1 << m_sel) : 64'd0);
    for (int k = 0; k < 5; k++)
      chk($sformatf("s%0d_payload", k),
          64'(spay[k]), 64'(m_hold));
    chk("ord_sel", 64'(ord_sel),
        (q.size() > 0) ? 64'(q[0]) : 64'd0);
    chk("ord_empty", 64'(ord_empty),
        64'(q.size() == 0));
    chk("ord_full", 64'(ord_full),
        64'(q.size() == 8));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    go(1, 32'h4000_0000, 2'd1, 5'h1f, 1);
    go(1, 32'h0, 2'd3, 5'h1f, 0);
    reset = 1'b0;
  endtask

  logic [31:0] fa;

  initial begin
    m_if.ARVALID = 1'b0;
    @(negedge clk);
    do_reset();

    // Single request to slave 2.
    go(1, 32'h4000_0000, 2'd2, 5'b0, 0);
    chk("single_s2_id", 64'(s2_if.ARID), 64'h20);
    chk("single_ord_sel", 64'(ord_sel), 64'd2);
    go(0, 32'h0, 2'd0, 5'b00100, 0);
    chk("single_s2_clr", 64'(s2_if.ARVALID), 64'd0);

    // Default-slave decode.
    go(1, 32'hE000_0000, 2'd0, 5'b0, 1);
    chk("dflt_s4_vld", 64'(s4_if.ARVALID), 64'd1);
    go(0, 32'h0, 2'd0, 5'b10000, 0);
    chk("dflt_ord_sel", 64'(ord_sel), 64'd4);
    go(0, 32'h0, 2'd0, 5'b0, 1);

    // Stall on slave 1, then back-to-back.
    do_reset();
    go(1, 32'h2000_0000, 2'd0, 5'b0, 0);
    for (int i = 0; i < 3; i++)
      go(1, 32'h2000_0000, 2'd1, 5'b0, 0);
    chk("stall_s1_vld", 64'(s1_if.ARVALID), 64'd1);
    chk("stall_s1_id", 64'(s1_if.ARID), 64'h00);
    go(1, 32'h2000_0000, 2'd1, 5'b00010, 0);
    chk("b2b_s1_id", 64'(s1_if.ARID), 64'h11);
    go(0, 32'h0, 2'd0, 5'h1f, 1);

    // Fill the order FIFO.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      case (i % 3)
        0: fa = 32'h0000_0000;
        1: fa = 32'h6000_0000;
        default: fa = 32'h2000_0000;
      endcase
      go(1, fa, 2'(i), 5'h1f, 0);
    end
    chk("full_flag", 64'(ord_full), 64'd1);
    chk("full_head", 64'(ord_sel), 64'd0);
    go(1, 32'h8000_0000, 2'd0, 5'h1f, 0);
    go(1, 32'h8000_0000, 2'd0, 5'h1f, 1);
    chk("pop_head", 64'(ord_sel), 64'd3);
    go(1, 32'h8000_0000, 2'd0, 5'h1f, 0);
    for (int i = 0; i < 10; i++)
      go(0, 32'h0, 2'd0, 5'h1f, 1);

    // Sequence wrap after 16 tags.
    do_reset();
    for (int i = 0; i < 17; i++)
      go(1, $urandom, 2'd1, 5'h1f, 1);
    chk("seq_wrap_id", 64'(s0_if.ARID), 64'h10);

    // Reset while busy with queued entries.
    do_reset();
    for (int i = 0; i < 3; i++)
      go(1, 32'h4000_0000, 2'd2, 5'h1f, 0);
    go(1, 32'h4000_0000, 2'd0, 5'b0, 0);
    reset = 1'b1;
    go(0, 32'h0, 2'd0, 5'b0, 0);
    reset = 1'b0;
    chk("rst_mid_vld", 64'(svld), 64'd0);
    chk("rst_mid_empty", 64'(ord_empty), 64'd1);
    go(1, 32'h0, 2'd3, 5'b0, 0);
    chk("rst_mid_seq", 64'(s0_if.ARID), 64'h30);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      go($urandom_range(0, 3) != 0, $urandom,
         2'($urandom), 5'($urandom),
         $urandom_range(0, 2) == 0);
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
